// File: rtl/buttons_wb.sv
// rtl/buttons_wb.sv - Wishbone-readable debounced push-button block
//
// Purpose: synchronizes and debounces N_BTN active-low button pads and exposes
// the debounced pressed state plus sticky press/release flags on a single
// Wishbone slave slot (no address decoding). Flags clear on a read ack.
//
// Ports:
//   clk       - system clock
//   reset     - asynchronous active-low reset
//   wb_cyc    - slave select / cycle strobe
//   wb_we     - write enable (writes are acked and ignored)
//   wb_rdata  - read data, non-zero only during the ack cycle
//   wb_ack    - single-cycle acknowledge
//   btn       - raw pad levels, 0 = pressed
//
// Read word: [N_BTN-1:0] state, [8+N_BTN-1:8] press_flag,
//            [16+N_BTN-1:16] release_flag, all other bits 0.

module buttons_wb #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_cyc,
    input  logic             wb_we,
    output logic [31:0]      wb_rdata,
    output logic             wb_ack,
    input  logic [N_BTN-1:0] btn
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] pressed_raw;
    logic [N_BTN-1:0] state;
    logic [N_BTN-1:0] toggle;
    logic [N_BTN-1:0] press_flag;
    logic [N_BTN-1:0] release_flag;
    logic [N_BTN-1:0] press_next;
    logic [N_BTN-1:0] release_next;
    logic [CW-1:0]    cnt      [N_BTN];
    logic [CW-1:0]    cnt_next [N_BTN];
    logic             ack_edge;
    logic             read_clear;
    logic [31:0]      status;

    assign pressed_raw = ~sync2;

    // The edge that raises ack is the edge that samples the status word.
    assign ack_edge   = wb_cyc && !wb_ack;
    assign read_clear = ack_edge && !wb_we;

    // Counting to DEBOUNCE_CYCLES means the toggle happens on the edge where
    // the counter already holds DEBOUNCE_CYCLES-1 and the mismatch persists.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            toggle[i]   = 1'b0;
            cnt_next[i] = cnt[i] + CW'(1);
            if (pressed_raw[i] == state[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                cnt_next[i] = '0;
                toggle[i]   = 1'b1;
            end
        end
    end

    // A transition on the clearing edge wins over the clear.
    always_comb begin
        press_next   = (read_clear ? '0 : press_flag)   | (toggle & ~state);
        release_next = (read_clear ? '0 : release_flag) | (toggle & state);
    end

    always_comb begin
        status                = '0;
        status[N_BTN-1:0]     = state;
        status[8 +: N_BTN]    = press_flag;
        status[16 +: N_BTN]   = release_flag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1        <= '1;
            sync2        <= '1;
            state        <= '0;
            press_flag   <= '0;
            release_flag <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1        <= btn;
            sync2        <= sync1;
            state        <= state ^ toggle;
            press_flag   <= press_next;
            release_flag <= release_next;
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_ack   <= 1'b0;
            wb_rdata <= '0;
        end else begin
            wb_ack   <= ack_edge;
            wb_rdata <= ack_edge ? status : 32'h0;
        end
    end

endmodule

// File: tb/tb_buttons_wb.sv
// tb/tb_buttons_wb.sv - self-checking bench for buttons_wb

module tb_buttons_wb;

    logic        clk;
    logic        reset;
    logic        wb_cyc;
    logic        wb_we;
    logic [31:0] wb_rdata;
    logic        wb_ack;
    logic [1:0]  btn;

    int vectors;
    int miscompares;
    logic [31:0] exp_q[$];

    buttons_wb #(
        .N_BTN(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wb_cyc(wb_cyc),
        .wb_we(wb_we),
        .wb_rdata(wb_rdata),
        .wb_ack(wb_ack),
        .btn(btn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Read cycle: expected word queued at issue, popped when ack appears.
    task automatic issue_read(input logic [31:0] exp, input string name);
        logic [31:0] e;
        exp_q.push_back(exp);
        wb_we  = 1'b0;
        wb_cyc = 1'b1;
        @(negedge clk);
        vectors++;
        if (wb_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_ack got=%b want=1", name, wb_ack);
        end
        e = exp_q.pop_front();
        vectors++;
        if (wb_rdata !== e) begin
            miscompares++;
            $display("FAIL %s_rdata got=%h want=%h", name, wb_rdata, e);
        end
        wb_cyc = 1'b0;
        @(negedge clk);
        vectors++;
        if (wb_ack !== 1'b0 || wb_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL %s_idle got ack=%b rdata=%h want ack=0 rdata=0", name, wb_ack, wb_rdata);
        end
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
        btn    = 2'b11;
        wait_cycles(3);
        vectors++;
        if (wb_ack !== 1'b0 || wb_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got ack=%b rdata=%h want ack=0 rdata=0", wb_ack, wb_rdata);
        end
        reset = 1'b1;
        wait_cycles(2);
        issue_read(32'h0000_0000, "reset_read");
    endtask

    task automatic test_glitch;
        btn[1] = 1'b0;
        wait_cycles(3);
        btn[1] = 1'b1;
        wait_cycles(8);
        issue_read(32'h0000_0000, "glitch");
    endtask

    task automatic test_press;
        btn[0] = 1'b0;
        wait_cycles(6);
        issue_read(32'h0000_0101, "press");
        issue_read(32'h0000_0001, "press_clear");
    endtask

    task automatic test_release;
        btn[0] = 1'b1;
        wait_cycles(6);
        issue_read(32'h0001_0000, "release");
        issue_read(32'h0000_0000, "release_clear");
    endtask

    // btn[1] driven before edge 0 so the ack edge of this read is edge 5.
    task automatic test_collision;
        btn[1] = 1'b0;
        wait_cycles(5);
        issue_read(32'h0000_0000, "collide_same_edge");
        issue_read(32'h0000_0202, "collide_after");
    endtask

    task automatic test_write;
        btn[1] = 1'b1;
        wait_cycles(6);
        wb_we  = 1'b1;
        wb_cyc = 1'b1;
        @(negedge clk);
        vectors++;
        if (wb_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL write_ack got=%b want=1", wb_ack);
        end
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
        @(negedge clk);
        vectors++;
        if (wb_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL write_ack_end got=%b want=0", wb_ack);
        end
        issue_read(32'h0002_0000, "write_keeps_flags");
        issue_read(32'h0000_0000, "write_then_clear");
    endtask

    task automatic test_held_cyc;
        logic [5:0] pattern;
        pattern = 6'b101010;
        wb_we  = 1'b0;
        wb_cyc = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (wb_ack !== pattern[i] || wb_rdata !== 32'h0) begin
                miscompares++;
                $display("FAIL held_cyc[%0d] got ack=%b rdata=%h want ack=%b rdata=0",
                         i, wb_ack, wb_rdata, pattern[i]);
            end
            @(negedge clk);
        end
        wb_cyc = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_reset_abort;
        btn[0] = 1'b0;
        wait_cycles(6);
        wb_we  = 1'b0;
        wb_cyc = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (wb_ack !== 1'b1 || wb_rdata !== 32'h0000_0101) begin
            miscompares++;
            $display("FAIL abort_pre got ack=%b rdata=%h want ack=1 rdata=00000101", wb_ack, wb_rdata);
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (wb_ack !== 1'b0 || wb_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_reset got ack=%b rdata=%h want ack=0 rdata=0", wb_ack, wb_rdata);
        end
        wb_cyc = 1'b0;
        btn    = 2'b11;
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(2);
        issue_read(32'h0000_0000, "abort_after");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_glitch();
        test_press();
        test_release();
        test_collision();
        test_write();
        test_held_cyc();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
